gen_imm_pipe: RTL and testbench

//  Parametrised, pipelined immediate generator for the RV32I/RV64I decode stage of the pipelined core.

---
 rtl/gen_imm_pipe.sv | 154 +++++++++++++++
 tb/tb_gen_imm_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/gen_imm_pipe.sv
// Pipelined RV32I/RV64I immediate generator with valid/ready flow control.
// Optional macro GEN_IMM_CSR_EN adds CSR-zimm/CSR-address decode for SYSTEM opcodes.
module gen_imm_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 1
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iValid,
  output logic            oReady,
  input  logic [31:0]     iInst,
  output logic            oValid,
  input  logic            iReady,
  output logic [XLEN-1:0] oImm,
  output logic [2:0]      oFmt,
  output logic            oHasImm
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;
`ifdef GEN_IMM_CSR_EN
  localparam logic [2:0] FMT_ZIMM  = 3'd7;
`endif

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;

  assign opcode = iInst[6:0];
  assign funct3 = iInst[14:12];

  // Combinational decode feeding stage 0
  always_comb begin
    dec_imm = '0;
    dec_fmt = FMT_NONE;
    case (opcode)
      7'b0000011, 7'b1100111: begin
        dec_imm = XLEN'($signed(iInst[31:20]));
        dec_fmt = FMT_I;
      end
      7'b0010011: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec_fmt = FMT_SHAMT;
          if (XLEN == 64) dec_imm = XLEN'(iInst[25:20]);
          else            dec_imm = XLEN'(iInst[24:20]);
        end else begin
          dec_imm = XLEN'($signed(iInst[31:20]));
          dec_fmt = FMT_I;
        end
      end
      7'b0100011: begin
        dec_imm = XLEN'($signed({iInst[31:25], iInst[11:7]}));
        dec_fmt = FMT_S;
      end
      7'b1100011: begin
        dec_imm = XLEN'($signed({iInst[31], iInst[7], iInst[30:25], iInst[11:8], 1'b0}));
        dec_fmt = FMT_B;
      end
      7'b0110111, 7'b0010111: begin
        dec_imm = XLEN'($signed({iInst[31:12], 12'b0}));
        dec_fmt = FMT_U;
      end
      7'b1101111: begin
        dec_imm = XLEN'($signed({iInst[31], iInst[19:12], iInst[20], iInst[30:21], 1'b0}));
        dec_fmt = FMT_J;
      end
`ifdef GEN_IMM_CSR_EN
      7'b1110011: begin
        if (funct3[2]) begin
          dec_imm = XLEN'(iInst[19:15]);
          dec_fmt = FMT_ZIMM;
        end else begin
          dec_imm = XLEN'($signed(iInst[31:20]));
          dec_fmt = FMT_I;
        end
      end
`endif
      default: begin
        dec_imm = '0;
        dec_fmt = FMT_NONE;
      end
    endcase
  end

  logic [STAGES-1:0] v_q, v_d, adv, load;
  logic [STAGES:0]   down_ok;
  logic [XLEN-1:0]   imm_q [STAGES];
  logic [XLEN-1:0]   imm_d [STAGES];
  logic [2:0]        fmt_q [STAGES];
  logic [2:0]        fmt_d [STAGES];

  // down_ok[k]: stage k can take a word this cycle (empty or draining)
  always_comb begin
    down_ok         = '0;
    adv             = '0;
    load            = '0;
    down_ok[STAGES] = iReady;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      adv[k]     = v_q[k] & down_ok[k+1];
      load[k]    = ~v_q[k] | adv[k];
      down_ok[k] = load[k];
    end
  end

  assign oReady = down_ok[0];

  always_comb begin
    v_d   = v_q;
    imm_d = imm_q;
    fmt_d = fmt_q;
    if (load[0]) begin
      v_d[0] = iValid;
      if (iValid) begin
        imm_d[0] = dec_imm;
        fmt_d[0] = dec_fmt;
      end
    end
    for (int k = 1; k < int'(STAGES); k++) begin
      if (load[k]) begin
        v_d[k] = v_q[k-1];
        if (v_q[k-1]) begin
          imm_d[k] = imm_q[k-1];
          fmt_d[k] = fmt_q[k-1];
        end
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      v_q <= '0;
      for (int k = 0; k < int'(STAGES); k++) begin
        imm_q[k] <= '0;
        fmt_q[k] <= FMT_NONE;
      end
    end else begin
      v_q   <= v_d;
      imm_q <= imm_d;
      fmt_q <= fmt_d;
    end
  end

  assign oValid  = v_q[STAGES-1];
  assign oImm    = imm_q[STAGES-1];
  assign oFmt    = fmt_q[STAGES-1];
  assign oHasImm = (fmt_q[STAGES-1] != FMT_NONE);

endmodule

// File: tb/tb_gen_imm_pipe.sv
// Randomized and directed bench for gen_imm_pipe against an arithmetic reference decoder.
module tb_gen_imm_pipe;
  localparam int unsigned XLEN   = 32;
  localparam int unsigned STAGES = 3;

  logic            iCLK = 1'b0;
  logic            iRST;
  logic            iValid;
  logic            oReady;
  logic [31:0]     iInst;
  logic            oValid;
  logic            iReady;
  logic [XLEN-1:0] oImm;
  logic [2:0]      oFmt;
  logic            oHasImm;

  gen_imm_pipe #(.XLEN(XLEN), .STAGES(STAGES)) dut (
    .iCLK(iCLK), .iRST(iRST), .iValid(iValid), .oReady(oReady), .iInst(iInst),
    .oValid(oValid), .iReady(iReady), .oImm(oImm), .oFmt(oFmt), .oHasImm(oHasImm)
  );

  always #5 iCLK = ~iCLK;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb_q[$];
  logic        hold_pending = 1'b0;
  logic [63:0] hold_imm;
  logic [2:0]  hold_fmt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: immediates rebuilt as signed integers from field weights
  function automatic void ref_dec(input logic [31:0] in, output logic [63:0] imm, output logic [2:0] fmt);
    longint v;
    logic [63:0] t;
    v = 0;
    fmt = 3'd0;
    case (in[6:0])
      7'b0000011, 7'b1100111: begin fmt = 3'd1; v = longint'(in[31:20]); if (v >= 2048) v -= 4096; end
      7'b0010011: begin
        if (in[14:12] == 3'b001 || in[14:12] == 3'b101) begin
          fmt = 3'd6;
          v = (XLEN == 64) ? longint'(in[25:20]) : longint'(in[24:20]);
        end else begin
          fmt = 3'd1; v = longint'(in[31:20]); if (v >= 2048) v -= 4096;
        end
      end
      7'b0100011: begin
        fmt = 3'd2; v = longint'(in[11:7]) + longint'(in[31:25]) * 32;
        if (v >= 2048) v -= 4096;
      end
      7'b1100011: begin
        fmt = 3'd3;
        v = longint'(in[11:8]) * 2 + longint'(in[30:25]) * 32 + longint'(in[7]) * 2048 + longint'(in[31]) * 4096;
        if (in[31]) v -= 8192;
      end
      7'b0110111, 7'b0010111: begin
        fmt = 3'd4; v = longint'(in[31:12]) * 4096;
        if (in[31]) v -= 64'sh1_0000_0000;
      end
      7'b1101111: begin
        fmt = 3'd5;
        v = longint'(in[30:21]) * 2 + longint'(in[20]) * 2048 + longint'(in[19:12]) * 4096
            + longint'(in[31]) * (64'sd1 << 20);
        if (in[31]) v -= (64'sd1 << 21);
      end
`ifdef GEN_IMM_CSR_EN
      7'b1110011: begin
        if (in[14]) begin fmt = 3'd7; v = longint'(in[19:15]); end
        else begin fmt = 3'd1; v = longint'(in[31:20]); if (v >= 2048) v -= 4096; end
      end
`endif
      default: begin fmt = 3'd0; v = 0; end
    endcase
    t = 64'(v);
    if (XLEN == 32) t[63:32] = 32'h0;
    imm = t;
  endfunction

  function automatic logic [31:0] rnd_inst();
    logic [6:0]  op;
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 11))
      0: op = 7'b0000011;  1: op = 7'b1100111;  2: op = 7'b0010011;
      3: op = 7'b0100011;  4: op = 7'b1100011;  5: op = 7'b0110111;
      6: op = 7'b0010111;  7: op = 7'b1101111;  8: op = 7'b1110011;
      9: op = 7'b0110011;  10: op = 7'b0010011;
      default: op = 7'($urandom());
    endcase
    return {r[31:7], op};
  endfunction

  // One clock: drive at posedge+1, observe at negedge, return at next posedge+1
  task automatic step(input logic v, input logic [31:0] inst, input logic rdy, output logic took);
    logic [63:0] ei;
    logic [2:0]  ef;
    logic        exp_rdy;
    iValid = v; iInst = inst; iReady = rdy;
    @(negedge iCLK);
    if (hold_pending) begin
      check_eq("hold_valid", 64'(oValid), 64'd1);
      check_eq("hold_imm", 64'(oImm), hold_imm);
      check_eq("hold_fmt", 64'(oFmt), 64'(hold_fmt));
    end
    exp_rdy = (sb_q.size() < int'(STAGES)) || (oValid && iReady);
    check_eq("ready", 64'(oReady), 64'(exp_rdy));
    hold_pending = oValid && !iReady;
    hold_imm = 64'(oImm);
    hold_fmt = oFmt;
    if (oValid && iReady) begin
      if (sb_q.size() == 0) begin
        check_eq("stale_word", 64'(oValid), 64'd0);
      end else begin
        ref_dec(sb_q.pop_front(), ei, ef);
        check_eq("imm", 64'(oImm), ei);
        check_eq("fmt", 64'(oFmt), 64'(ef));
        check_eq("has_imm", 64'(oHasImm), 64'(ef != 3'd0));
      end
    end
    took = iValid && oReady;
    if (took) sb_q.push_back(iInst);
    @(posedge iCLK); #1;
  endtask

  task automatic drain(input string tag);
    logic t;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) step(1'b0, 32'h0, 1'b1, t);
    check_eq(tag, 64'(sb_q.size()), 64'd0);
    step(1'b0, 32'h0, 1'b1, t);
  endtask

  // Single word into an empty pipe: latency and spec-given constants
  task automatic directed(input string tag, input logic [31:0] inst, input logic [63:0] e_imm, input logic [2:0] e_fmt);
    logic [63:0] e;
    int lat;
    e = e_imm;
    if (XLEN == 32) e[63:32] = 32'h0;
    iValid = 1'b1; iInst = inst; iReady = 1'b1;
    @(negedge iCLK);
    check_eq({tag, "_ready"}, 64'(oReady), 64'd1);
    @(posedge iCLK); #1;
    iValid = 1'b0;
    lat = 1;
    while (!oValid && lat < 20) begin
      @(posedge iCLK); #1;
      lat++;
    end
    check_eq({tag, "_latency"}, 64'(lat), 64'(STAGES));
    check_eq({tag, "_imm"}, 64'(oImm), e);
    check_eq({tag, "_fmt"}, 64'(oFmt), 64'(e_fmt));
    check_eq({tag, "_has"}, 64'(oHasImm), 64'(e_fmt != 3'd0));
    @(posedge iCLK); #1;
  endtask

  initial begin
    logic t;
    int sent;
    iRST = 1'b1; iValid = 1'b0; iReady = 1'b0; iInst = 32'h0;
    repeat (2) @(posedge iCLK);
    #1;
    check_eq("rst_valid", 64'(oValid), 64'd0);
    check_eq("rst_imm", 64'(oImm), 64'd0);
    check_eq("rst_fmt", 64'(oFmt), 64'd0);
    check_eq("rst_has", 64'(oHasImm), 64'd0);
    @(negedge iCLK); iRST = 1'b0;
    @(posedge iCLK); #1;
    check_eq("rst_ready", 64'(oReady), 64'd1);

    directed("lui",   32'h12345037, 64'h0000_0000_1234_5000, 3'd4);
    directed("beq",   32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3);
    directed("addi",  32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1);
    directed("srai",  32'h4030D093, 64'd3, 3'd6);
    directed("add",   32'h00000033, 64'd0, 3'd0);
`ifdef GEN_IMM_CSR_EN
    directed("csrwi", 32'h3002D073, 64'd5, 3'd7);
`else
    directed("csrwi", 32'h3002D073, 64'd0, 3'd0);
`endif

    // 8-word burst with consumer stalled on cycles 3..5
    sent = 0;
    for (int c = 0; c < 40 && (sent < 8 || sb_q.size() != 0); c++) begin
      step(sent < 8, rnd_inst(), !(c >= 3 && c <= 5), t);
      if (t) sent++;
    end
    check_eq("burst_sent", 64'(sent), 64'd8);
    drain("burst_drain");

    // Reset with words in flight
    step(1'b1, 32'h12345037, 1'b0, t);
    step(1'b1, 32'hFFF00093, 1'b0, t);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, t);
    #2 iRST = 1'b1;
    #1;
    check_eq("midrst_valid", 64'(oValid), 64'd0);
    check_eq("midrst_imm", 64'(oImm), 64'd0);
    check_eq("midrst_fmt", 64'(oFmt), 64'd0);
    sb_q.delete();
    hold_pending = 1'b0;
    @(posedge iCLK); #2 iRST = 1'b0;
    @(posedge iCLK); #1;
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, t);

    // Random traffic
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 9) < 7, rnd_inst(), $urandom_range(0, 9) < 6, t);
    drain("rand_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
